// File: rtl/addsub_serial_nibble.sv
`default_nettype none
// ============================================================================
// Module   : addsub_serial_nibble
// Purpose  : Word-width add/subtract built from one reused 4-bit add slice,
//            one nibble per clock, LSB nibble first, start/busy/done handshake.
// Revision : 1.0  initial release
// ============================================================================
module addsub_serial_nibble #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               M,
  input  logic [4*WORDS-1:0] A,
  input  logic [4*WORDS-1:0] B,
  output logic               busy,
  output logic               done,
  output logic [4*WORDS-1:0] z,
  output logic               C,
  output logic               V
);

  localparam int c_W  = 4 * WORDS;
  localparam int c_IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(WORDS - 1);

  // A single-nibble operand would make the serial slice pointless.
  generate
    if (WORDS < 2 || WORDS > 8) begin : g_words_check
      $error("addsub_serial_nibble: WORDS must be in 2..8");
    end
  endgenerate

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [c_W-1:0]    r_a;
  logic [c_W-1:0]    r_b;
  logic              r_m;
  logic              r_carry;
  logic [c_IW-1:0]   r_idx;
  logic [c_W-1:0]    r_sum;
  logic [c_W-1:0]    r_z;
  logic              r_c;
  logic              r_v;
  logic              r_done;

  logic [3:0]        w_a_nib;
  logic [3:0]        w_b_nib;
  logic [3:0]        w_bx_nib;
  logic [4:0]        w_s;
  logic [c_W-1:0]    w_result;
  logic              w_last;
  logic              w_v;

  // Select the current nibble of each latched operand and merge the slice
  // output into the partial result so the final edge sees the full word.
  always_comb begin
    w_a_nib  = 4'h0;
    w_b_nib  = 4'h0;
    w_result = r_sum;
    for (int i = 0; i < WORDS; i++) begin
      if (r_idx == c_IW'(i)) begin
        w_a_nib = r_a[4*i +: 4];
        w_b_nib = r_b[4*i +: 4];
      end
    end
    w_bx_nib = w_b_nib ^ {4{r_m}};
    w_s      = {1'b0, w_a_nib} + {1'b0, w_bx_nib} + {4'h0, r_carry};
    for (int i = 0; i < WORDS; i++) begin
      if (r_idx == c_IW'(i)) begin
        w_result[4*i +: 4] = w_s[3:0];
      end
    end
    w_last = (r_state == S_RUN) && (r_idx == c_LAST);
    // Overflow: operands (after conditional inversion) agree in sign but the
    // result sign differs from A.
    w_v    = ((r_a[c_W-1] == (r_b[c_W-1] ^ r_m)) && (w_result[c_W-1] != r_a[c_W-1]));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: accept start only in IDLE, leave RUN after the last nibble.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, step one nibble per RUN cycle, and
  // publish z/C/V together with the done pulse only on the final nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_z     <= '0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_m     <= M;
            r_carry <= M;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum   <= w_result;
          r_carry <= w_s[4];
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_z    <= w_result;
            r_c    <= w_s[4];
            r_v    <= w_v;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign z    = r_z;
  assign C    = r_c;
  assign V    = r_v;

endmodule
`default_nettype wire
